q_mul_vec: RTL and testbench

//   Multi-lane, parametrised quantized multiplier for the NPU datapath. Per lane it computes
//   C = requant2(requant0(A*B) + requant1(A' + B')), with selectable offset-corrected inputs A'/B'.

---
 rtl/q_mul_vec.sv | 156 +++++++++++++++
 tb/tb_q_mul_vec.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/q_mul_vec.sv
// Multi-lane quantized multiplier: C = requant2(requant0(A*B) + requant1(A'+B')) per lane,
// three register stages under a global stall, with output min/max/saturation statistics.
module q_mul_vec #(
    parameter int DW    = 8,
    parameter int LANES = 4,
    parameter int GW    = 16,
    parameter int SW    = 5
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [LANES*DW-1:0]   a_in_i,
    input  logic [LANES*DW-1:0]   b_in_i,
    input  logic [LANES*DW-1:0]   a_in_inv_i,
    input  logic [LANES*DW-1:0]   b_in_inv_i,
    input  logic                  a_sel_inv_i,
    input  logic                  b_sel_inv_i,
    input  logic [GW-1:0]         ml0_gain_i,
    input  logic [SW-1:0]         ml0_shift_i,
    input  logic [DW-1:0]         ml0_zp_i,
    input  logic [GW-1:0]         ml1_gain_i,
    input  logic [SW-1:0]         ml1_shift_i,
    input  logic [DW-1:0]         ml1_zp_i,
    input  logic [GW-1:0]         ml2_gain_i,
    input  logic [SW-1:0]         ml2_shift_i,
    input  logic [DW-1:0]         ml2_zp_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [LANES*DW-1:0]   c_out_o,
    input  logic                  stat_clr_i,
    output logic [DW-1:0]         min_o,
    output logic [DW-1:0]         max_o,
    output logic [15:0]           sat_cnt_o,
    output logic                  busy_o
);

    localparam int XW = 2 * DW;
    localparam int PW = XW + GW + 1;
    localparam logic [DW-1:0] MAXV = '1;

    // Unclipped requant result; PW bits hold the largest product plus rounding term without wrap.
    function automatic logic [PW-1:0] scale(input logic [XW-1:0] x, input logic [GW-1:0] g,
                                            input logic [SW-1:0] s, input logic [DW-1:0] z);
        logic [PW-1:0] acc;
        acc = PW'(x) * PW'(g);
        if (s != '0)
            acc = acc + (PW'(1) << (s - SW'(1)));
        acc = (acc >> s) + PW'(z);
        return acc;
    endfunction

    function automatic logic [DW-1:0] clip(input logic [PW-1:0] v);
        return (v > PW'(MAXV)) ? MAXV : v[DW-1:0];
    endfunction

    logic                  en;
    logic                  handshake;
    logic                  v1_q, v2_q, v3_q;
    logic [DW-1:0]         p_q [LANES];
    logic [DW-1:0]         q_q [LANES];
    logic [DW:0]           s_q [LANES];
    logic [DW-1:0]         c_q [LANES];
    logic [LANES-1:0]      sat_q;
    logic [PW-1:0]         wMul [LANES];
    logic [PW-1:0]         wAdd [LANES];
    logic [PW-1:0]         wOut [LANES];
    logic [DW-1:0]         aOp [LANES];
    logic [DW-1:0]         bOp [LANES];
    logic [DW-1:0]         aAdd [LANES];
    logic [DW-1:0]         bAdd [LANES];
    logic [DW-1:0]         min_q, min_d;
    logic [DW-1:0]         max_q, max_d;
    logic [15:0]           satCnt_q, satCnt_d;
    logic [16:0]           cntSum;

    assign en          = !v3_q | out_ready_i;
    assign in_ready_o  = en & !reset_i;
    assign handshake   = v3_q & out_ready_i;
    assign out_valid_o = v3_q;
    assign busy_o      = v1_q | v2_q | v3_q;
    assign min_o       = min_q;
    assign max_o       = max_q;
    assign sat_cnt_o   = satCnt_q;

    always_comb begin
        c_out_o = '0;
        for (int i = 0; i < LANES; i++) begin
            aOp[i]  = a_in_i[i*DW +: DW];
            bOp[i]  = b_in_i[i*DW +: DW];
            aAdd[i] = a_sel_inv_i ? a_in_inv_i[i*DW +: DW] : a_in_i[i*DW +: DW];
            bAdd[i] = b_sel_inv_i ? b_in_inv_i[i*DW +: DW] : b_in_i[i*DW +: DW];
            wMul[i] = scale(XW'(aOp[i]) * XW'(bOp[i]), ml0_gain_i, ml0_shift_i, ml0_zp_i);
            wAdd[i] = scale(XW'(aAdd[i]) + XW'(bAdd[i]), ml1_gain_i, ml1_shift_i, ml1_zp_i);
            wOut[i] = scale(XW'(s_q[i]), ml2_gain_i, ml2_shift_i, ml2_zp_i);
            c_out_o[i*DW +: DW] = c_q[i];
        end
    end

    // All three stages move together; a bubble simply carries valid=0 forward.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            sat_q <= '0;
            for (int i = 0; i < LANES; i++) begin
                p_q[i] <= '0;
                q_q[i] <= '0;
                s_q[i] <= '0;
                c_q[i] <= '0;
            end
        end else if (en) begin
            v1_q <= in_valid_i;
            v2_q <= v1_q;
            v3_q <= v2_q;
            for (int i = 0; i < LANES; i++) begin
                p_q[i]   <= clip(wMul[i]);
                q_q[i]   <= clip(wAdd[i]);
                s_q[i]   <= {1'b0, p_q[i]} + {1'b0, q_q[i]};
                c_q[i]   <= clip(wOut[i]);
                sat_q[i] <= (wOut[i] > PW'(MAXV));
            end
        end
    end

    // A clear coinciding with a handshake restarts the stats from that beat alone.
    always_comb begin
        min_d  = stat_clr_i ? MAXV : min_q;
        max_d  = stat_clr_i ? '0 : max_q;
        cntSum = stat_clr_i ? 17'd0 : {1'b0, satCnt_q};
        if (handshake) begin
            for (int i = 0; i < LANES; i++) begin
                if (c_q[i] < min_d)
                    min_d = c_q[i];
                if (c_q[i] > max_d)
                    max_d = c_q[i];
                cntSum = cntSum + 17'(sat_q[i]);
            end
        end
        satCnt_d = (cntSum > 17'h0FFFF) ? 16'hFFFF : cntSum[15:0];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            min_q    <= MAXV;
            max_q    <= '0;
            satCnt_q <= '0;
        end else begin
            min_q    <= min_d;
            max_q    <= max_d;
            satCnt_q <= satCnt_d;
        end
    end

endmodule

// File: tb/tb_q_mul_vec.sv
// Directed testbench for q_mul_vec: hand-computed lane results, backpressure ordering,
// statistics clear/saturation and mid-stream reset.
module tb_q_mul_vec;

    logic        clk;
    logic        reset;
    logic        inValid;
    logic        inReady;
    logic [31:0] aIn, bIn, aInv, bInv;
    logic        aSel, bSel;
    logic [15:0] ml0Gain, ml1Gain, ml2Gain;
    logic [4:0]  ml0Shift, ml1Shift, ml2Shift;
    logic [7:0]  ml0Zp, ml1Zp, ml2Zp;
    logic        outValid;
    logic        outReady;
    logic [31:0] cOut;
    logic        statClr;
    logic [7:0]  minV, maxV;
    logic [15:0] satCnt;
    logic        busy;

    int checkCount = 0;
    int passCount  = 0;
    logic [31:0] cGot;
    logic [31:0] expQ [$];

    q_mul_vec dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .in_valid_i  (inValid),
        .in_ready_o  (inReady),
        .a_in_i      (aIn),
        .b_in_i      (bIn),
        .a_in_inv_i  (aInv),
        .b_in_inv_i  (bInv),
        .a_sel_inv_i (aSel),
        .b_sel_inv_i (bSel),
        .ml0_gain_i  (ml0Gain),
        .ml0_shift_i (ml0Shift),
        .ml0_zp_i    (ml0Zp),
        .ml1_gain_i  (ml1Gain),
        .ml1_shift_i (ml1Shift),
        .ml1_zp_i    (ml1Zp),
        .ml2_gain_i  (ml2Gain),
        .ml2_shift_i (ml2Shift),
        .ml2_zp_i    (ml2Zp),
        .out_valid_o (outValid),
        .out_ready_i (outReady),
        .c_out_o     (cOut),
        .stat_clr_i  (statClr),
        .min_o       (minV),
        .max_o       (maxV),
        .sat_cnt_o   (satCnt),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected)
            passCount++;
        else
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    endtask

    task automatic setUnity();
        ml0Gain = 16'd1; ml0Shift = 5'd0; ml0Zp = 8'd0;
        ml1Gain = 16'd1; ml1Shift = 5'd0; ml1Zp = 8'd0;
        ml2Gain = 16'd1; ml2Shift = 5'd0; ml2Zp = 8'd0;
        aSel = 1'b0; bSel = 1'b0;
    endtask

    // One isolated beat; returns its result and checks the 3-cycle latency.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ai,
                                 input logic [31:0] bi, input logic clr, output logic [31:0] c);
        int lat;
        @(negedge clk);
        inValid = 1'b1; aIn = a; bIn = b; aInv = ai; bInv = bi;
        @(negedge clk);
        inValid = 1'b0;
        lat = 1;
        while (!outValid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("latency", lat, 3);
        c = cOut;
        statClr = clr;
        @(negedge clk);
        statClr = 1'b0;
    endtask

    initial begin
        int k;
        int got;
        int guard;
        reset = 1'b1; inValid = 1'b0; outReady = 1'b1; statClr = 1'b0;
        aIn = '0; bIn = '0; aInv = '0; bInv = '0;
        setUnity();
        repeat (2) @(negedge clk);
        checkOutput("rst outValid", outValid, 0);
        checkOutput("rst cOut", cOut, 0);
        checkOutput("rst min", minV, 8'hFF);
        checkOutput("rst max", maxV, 0);
        checkOutput("rst sat", satCnt, 0);
        checkOutput("rst busy", busy, 0);
        checkOutput("rst inReady", inReady, 0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("inReady after rst", inReady, 1);

        applyStimulus({8'd255, 8'd0, 8'd3, 8'd10}, {8'd2, 8'd0, 8'd4, 8'd20}, '0, '0, 1'b0, cGot);
        checkOutput("t1 C", cGot, 32'hFF0013E6);
        checkOutput("t1 min", minV, 0);
        checkOutput("t1 max", maxV, 255);
        checkOutput("t1 sat", satCnt, 1);

        ml0Gain = 16'd3; ml0Shift = 5'd2; ml1Gain = 16'd0;
        applyStimulus({8'd0, 8'd255, 8'd100, 8'd5}, {8'd9, 8'd255, 8'd3, 8'd1}, '0, '0, 1'b0, cGot);
        checkOutput("t2 C", cGot, 32'h00FFE104);
        checkOutput("t2 sat", satCnt, 1);

        setUnity();
        aSel = 1'b1;
        applyStimulus({4{8'd2}}, {4{8'd3}}, {4{8'd7}}, {4{8'd50}}, 1'b0, cGot);
        checkOutput("t3 aSel C", cGot, {4{8'd16}});
        aSel = 1'b0; bSel = 1'b1;
        applyStimulus({4{8'd2}}, {4{8'd3}}, {4{8'd70}}, {4{8'd9}}, 1'b0, cGot);
        checkOutput("t3 bSel C", cGot, {4{8'd17}});

        setUnity();
        ml2Gain = 16'd3; ml2Shift = 5'd1; ml2Zp = 8'd5;
        applyStimulus({8'd0, 8'd15, 8'd10, 8'd4}, {8'd0, 8'd10, 8'd10, 8'd5}, '0, '0, 1'b0, cGot);
        checkOutput("ml2 C", cGot, 32'h05FFB931);
        checkOutput("ml2 sat", satCnt, 2);

        // Backpressure: pipeline fills with exactly three beats, then drains in order.
        setUnity();
        outReady = 1'b0;
        k = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            inValid = 1'b1;
            aIn = {4{8'(k + 1)}};
            bIn = {4{8'd2}};
            if (inReady) begin
                expQ.push_back({4{8'(3 * k + 5)}});
                k++;
            end
        end
        @(negedge clk);
        inValid = 1'b0;
        checkOutput("bp accepted", k, 3);
        checkOutput("bp inReady", inReady, 0);
        checkOutput("bp outValid", outValid, 1);
        checkOutput("bp held C", cOut, 32'h05050505);
        outReady = 1'b1;
        got = 0;
        guard = 0;
        while (got < 3 && guard < 10) begin
            if (outValid) begin
                checkOutput("bp order", cOut, expQ.pop_front());
                got++;
            end
            @(negedge clk);
            guard++;
        end
        checkOutput("bp count", got, 3);
        checkOutput("bp busy", busy, 0);

        applyStimulus({4{8'd1}}, {4{8'd4}}, '0, '0, 1'b1, cGot);
        checkOutput("clr C", cGot, {4{8'd9}});
        checkOutput("clr min", minV, 9);
        checkOutput("clr max", maxV, 9);
        checkOutput("clr sat", satCnt, 0);

        @(negedge clk);
        inValid = 1'b1; aIn = {4{8'd255}}; bIn = {4{8'd255}};
        repeat (250) @(negedge clk);
        inValid = 1'b0;
        guard = 0;
        while (busy && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("stream drain", busy, 0);
        checkOutput("sat 250 beats", satCnt, 1000);
        checkOutput("stream max", maxV, 255);
        checkOutput("stream min", minV, 9);

        @(negedge clk);
        inValid = 1'b1;
        repeat (16200) @(negedge clk);
        inValid = 1'b0;
        guard = 0;
        while (busy && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("sat ceiling", satCnt, 16'hFFFF);

        // Reset with two beats in flight.
        inValid = 1'b1; aIn = {4{8'd1}}; bIn = {4{8'd1}};
        @(negedge clk);
        @(negedge clk);
        inValid = 1'b0;
        checkOutput("pre-rst busy", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midrst outValid", outValid, 0);
        checkOutput("midrst busy", busy, 0);
        checkOutput("midrst min", minV, 8'hFF);
        checkOutput("midrst max", maxV, 0);
        checkOutput("midrst sat", satCnt, 0);
        checkOutput("midrst inReady", inReady, 0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post-rst inReady", inReady, 1);
        applyStimulus({8'd255, 8'd0, 8'd3, 8'd10}, {8'd2, 8'd0, 8'd4, 8'd20}, '0, '0, 1'b0, cGot);
        checkOutput("post-rst C", cGot, 32'hFF0013E6);
        checkOutput("post-rst sat", satCnt, 1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
